incr_pipe: RTL

- Multi-channel, parametrised successor of the team's single-lane "data_out = data_in + 1, valid" bench DUT model.
- Accepts CHANNELS lanes of WIDTH-bit data per beat via valid/ready, applies a per-beat selectable operation (increment, pass-through, clear), and delivers results after a STAGES-deep elastic pipeline with full backpressure.
- Sits between bench drivers and scoreboards as a reusable reference DUT for clocking-block and skew experiments; fully synthesizable.

---
 rtl/incr_pipe_pkg.sv | 38 +++
 rtl/incr_pipe_if.sv | 26 ++
 rtl/incr_pipe_stage.sv | 28 ++
 rtl/incr_pipe.sv | 82 ++++++++
 4 files changed

// File: rtl/incr_pipe_pkg.sv
// Shared types and the per-lane operation for incr_pipe.
// INCR_PIPE_SAT_EN selects saturating instead of modular increment.
package incr_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_INCR = 2'd0,
    MODE_PASS = 2'd1,
    MODE_CLR  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Widest lane the helper supports; callers zero-extend in and truncate out.
  localparam int LANE_MAX_W = 32;

  function automatic logic [LANE_MAX_W-1:0] lane_op(
    input logic [LANE_MAX_W-1:0] lane,
    input logic [1:0]            mode,
    input logic [LANE_MAX_W-1:0] incr,
    input int unsigned           width
  );
    logic [LANE_MAX_W:0] mask;
    logic [LANE_MAX_W:0] sum;
    logic [LANE_MAX_W:0] res;
    mask = ((LANE_MAX_W+1)'(1) << width) - (LANE_MAX_W+1)'(1);
    sum  = ({1'b0, lane} & mask) + ({1'b0, incr} & mask);
    case (mode_e'(mode))
`ifdef INCR_PIPE_SAT_EN
      MODE_INCR: res = (sum > mask) ? mask : sum;
`else
      MODE_INCR: res = sum & mask;
`endif
      MODE_CLR:  res = '0;
      default:   res = {1'b0, lane} & mask;
    endcase
    return LANE_MAX_W'(res);
  endfunction

endpackage

// File: rtl/incr_pipe_if.sv
// Stream bundle for incr_pipe: input beat, output beat and beat counter.
// slave is the pipeline side, master is the driver/sink side.
interface incr_pipe_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_mode;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CNT_W-1:0]          beat_count;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, beat_count
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, beat_count
  );
endinterface

// File: rtl/incr_pipe_stage.sv
// One elastic register slot: valid + data, loads whenever empty or draining.
// Latency 1 cycle; up_rdy = !dn_vld || dn_rdy (combinational pass-through of ready).
module incr_pipe_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          up_vld,
  output logic          up_rdy,
  input  logic [DW-1:0] up_dat,
  output logic          dn_vld,
  input  logic          dn_rdy,
  output logic [DW-1:0] dn_dat
);

  assign up_rdy = !dn_vld || dn_rdy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dn_vld <= 1'b0;
      dn_dat <= '0;
    end else if (up_rdy) begin
      dn_vld <= up_vld;
      if (up_vld) dn_dat <= up_dat;
    end
  end

endmodule

// File: rtl/incr_pipe.sv
// Multi-lane increment/pass/clear pipeline with beat counter; INCR_PIPE_SAT_EN saturates lanes and counter.
// Latency STAGES cycles, 1 beat/cycle; full backpressure via a combinational ready chain, in_ready low in reset.
module incr_pipe
  import incr_pipe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int INCR     = 1,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         reset_n,
  incr_pipe_if.slave  bus
);

  localparam int DW = CHANNELS * WIDTH;

  logic [DW-1:0]    op_dat;
  logic             stg_vld [STAGES];
  logic             stg_rdy [STAGES];
  logic [DW-1:0]    stg_dat [STAGES];
  logic [CNT_W-1:0] cnt;

  // Each lane is evaluated on its own slice, so no carry crosses a lane boundary.
  always_comb begin
    op_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      op_dat[i*WIDTH +: WIDTH] = WIDTH'(lane_op(LANE_MAX_W'(bus.in_data[i*WIDTH +: WIDTH]),
                                                bus.in_mode, LANE_MAX_W'(INCR), WIDTH));
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic          up_vld;
    logic [DW-1:0] up_dat;
    logic          dn_rdy;

    if (s == 0) begin : g_head
      assign up_vld = bus.in_valid;
      assign up_dat = op_dat;
    end else begin : g_body
      assign up_vld = stg_vld[s-1];
      assign up_dat = stg_dat[s-1];
    end

    if (s == STAGES-1) begin : g_tail
      assign dn_rdy = bus.out_ready;
    end else begin : g_mid
      assign dn_rdy = stg_rdy[s+1];
    end

    incr_pipe_stage #(.DW(DW)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .up_vld  (up_vld),
      .up_rdy  (stg_rdy[s]),
      .up_dat  (up_dat),
      .dn_vld  (stg_vld[s]),
      .dn_rdy  (dn_rdy),
      .dn_dat  (stg_dat[s])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
`ifdef INCR_PIPE_SAT_EN
    end else if (bus.out_valid && bus.out_ready && (cnt != '1)) begin
`else
    end else if (bus.out_valid && bus.out_ready) begin
`endif
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready   = stg_rdy[0] && reset_n;
  assign bus.out_valid  = stg_vld[STAGES-1];
  assign bus.out_data   = stg_dat[STAGES-1];
  assign bus.beat_count = cnt;

endmodule
